// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file sizing and read-address helpers
package regfile_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_REGS = 32;
  localparam int ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;
  function automatic logic readable(input logic [ADDR_WIDTH-1:0] addr, input int unsigned num_regs);
    return addr != ZERO_REG && 32'(addr) < num_regs;
  endfunction
endpackage

// File: rtl/regfile_read_slice.sv
// regfile_read_slice: one read port with address hold, zero/bypass select and stall refresh
module regfile_read_slice
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat_i,
  input  logic                           wr_en_i,
  input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic                           accept_i,
  input  logic                           refresh_en_i,
  input  logic [ADDR_WIDTH-1:0]          rd_addr_i,
  output logic [DATA_WIDTH-1:0]          rd_data_o
);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] data_q, data_d, sel_data;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  refresh_hit;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
    assign regs[g] = regs_flat_i[g*DATA_WIDTH +: DATA_WIDTH];
  end
  // Zero register and out-of-range indices win over the bypass, which wins over the array.
  always_comb begin
    sel_data = !readable(rd_addr_i, NUM_REGS) ? '0 :
               (wr_en_i && wr_addr_i == rd_addr_i) ? wr_data_i : regs[rd_addr_i];
    refresh_hit = refresh_en_i && wr_en_i && wr_addr_i == addr_q && readable(addr_q, NUM_REGS);
    addr_d = accept_i ? rd_addr_i : addr_q;
    data_d = accept_i ? sel_data : refresh_hit ? wr_data_i : data_q;
  end
  // Held address and result register; reset parks the address on the zero register.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= ZERO_REG;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign rd_data_o = data_q;
endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port: dual registered read port with write bypass and stall hold
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_valid_in,
  input  logic [ADDR_WIDTH-1:0]          rd_addr_a,
  input  logic [ADDR_WIDTH-1:0]          rd_addr_b,
  input  logic                           stall,
  output logic                           rd_valid_out,
  output logic [DATA_WIDTH-1:0]          rd_data_a,
  output logic [DATA_WIDTH-1:0]          rd_data_b
);
  logic accept, valid_q, valid_d;
  assign accept = rd_valid_in && !stall;
  // A stall freezes the valid flag; otherwise it follows the incoming request.
  always_comb valid_d = stall ? valid_q : rd_valid_in;
  // Output valid register.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else valid_q <= valid_d;
  end
  assign rd_valid_out = valid_q;
  regfile_read_slice #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_port_a (
    .clk          (clk),
    .rst          (rst),
    .regs_flat_i  (regs_flat),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .accept_i     (accept),
    .refresh_en_i (stall && valid_q),
    .rd_addr_i    (rd_addr_a),
    .rd_data_o    (rd_data_a)
  );
  regfile_read_slice #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_port_b (
    .clk          (clk),
    .rst          (rst),
    .regs_flat_i  (regs_flat),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .accept_i     (accept),
    .refresh_en_i (stall && valid_q),
    .rd_addr_i    (rd_addr_b),
    .rd_data_o    (rd_data_b)
  );
endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: vector table, corner sequences and randomized model check
module tb_regfile_read_port;
  localparam int DW = 64;
  localparam int NR = 32;
  logic clk = 0;
  logic rst, wr_en, rd_valid_in, stall, rd_valid_out;
  logic [4:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [DW-1:0] wr_data, rd_data_a, rd_data_b;
  logic [NR*DW-1:0] regs_flat;
  logic [DW-1:0] regs [NR];
  int total = 0, bad = 0;
  typedef struct {
    logic r, v, s, we;
    logic [4:0] wa, aa, ab;
    logic [DW-1:0] wd;
    logic ev;
    logic [DW-1:0] ea, eb;
  } vec_t;
  vec_t tbl [8];
  logic m_v;
  logic [DW-1:0] m_a, m_b;
  logic [4:0] m_ha, m_hb;

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < NR; i++) regs_flat[i*DW +: DW] = regs[i];

  regfile_read_port dut (
    .clk(clk), .rst(rst), .regs_flat(regs_flat), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_valid_in(rd_valid_in), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .stall(stall), .rd_valid_out(rd_valid_out), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
  );

  function automatic vec_t mk(logic r, v, s, we, logic [4:0] wa, logic [DW-1:0] wd,
                              logic [4:0] aa, ab, logic ev, logic [DW-1:0] ea, eb);
    vec_t x;
    x.r = r; x.v = v; x.s = s; x.we = we; x.wa = wa; x.wd = wd;
    x.aa = aa; x.ab = ab; x.ev = ev; x.ea = ea; x.eb = eb;
    return x;
  endfunction

  task automatic drive(logic r, v, s, we, logic [4:0] wa, logic [DW-1:0] wd, logic [4:0] aa, ab);
    rst = r; rd_valid_in = v; stall = s; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = aa; rd_addr_b = ab;
  endtask

  task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic cyc(string n, logic ev, logic [DW-1:0] ea, eb);
    @(posedge clk);
    #1;
    chk({n, ".valid"}, DW'(rd_valid_out), DW'(ev));
    chk({n, ".a"}, rd_data_a, ea);
    chk({n, ".b"}, rd_data_b, eb);
  endtask

  function automatic logic [DW-1:0] rv(logic [4:0] a);
    if (a == 5'd31) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return regs[a];
  endfunction

  function automatic logic [4:0] pick();
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = {$urandom, $urandom};
    regs[1] = 64'h1001; regs[2] = 64'h2002; regs[3] = 64'h1234; regs[4] = 64'h11;
    regs[5] = 64'hAAAA; regs[7] = 64'hBEEF; regs[9] = 64'h5; regs[12] = 64'hC0DE;
    regs[31] = 64'hDEAD;
    tbl[0] = mk(1, 1, 0, 0, 0, 0, 5, 5, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0);
    tbl[2] = mk(0, 1, 0, 0, 0, 0, 3, 7, 1, 64'h1234, 64'hBEEF);
    tbl[3] = mk(0, 1, 0, 1, 4, 64'h99, 4, 31, 1, 64'h99, 0);
    tbl[4] = mk(0, 1, 0, 1, 31, 64'h77, 4, 31, 1, 64'h11, 0);
    tbl[5] = mk(0, 1, 0, 0, 0, 0, 12, 12, 1, 64'hC0DE, 64'hC0DE);
    tbl[6] = mk(0, 0, 0, 0, 0, 0, 3, 7, 0, 64'hC0DE, 64'hC0DE);
    tbl[7] = mk(0, 1, 0, 1, 31, 64'h77, 31, 31, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].aa, tbl[i].ab);
      cyc($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].eb);
    end
    drive(0, 1, 0, 0, 0, 0, 9, 3);           cyc("stall_accept", 1, 64'h5, 64'h1234);
    drive(0, 1, 1, 0, 0, 0, 1, 2);           cyc("stall_c1", 1, 64'h5, 64'h1234);
    drive(0, 1, 1, 1, 9, 64'h6, 1, 2);       cyc("stall_c2", 1, 64'h6, 64'h1234);
    drive(0, 1, 1, 0, 0, 0, 1, 2);           cyc("stall_c3", 1, 64'h6, 64'h1234);
    drive(0, 0, 0, 0, 0, 0, 1, 2);           cyc("stall_release", 0, 64'h6, 64'h1234);
    drive(0, 0, 1, 1, 9, 64'h8, 1, 2);       cyc("stall_idle_norefresh", 0, 64'h6, 64'h1234);
    drive(0, 1, 0, 0, 0, 0, 9, 9);           cyc("dual_accept", 1, 64'h5, 64'h5);
    drive(0, 0, 1, 1, 9, 64'h7, 0, 0);       cyc("dual_refresh", 1, 64'h7, 64'h7);
    drive(0, 1, 1, 1, 31, 64'h55, 31, 31);   cyc("refresh_zero_ignored", 1, 64'h7, 64'h7);
    drive(1, 1, 1, 1, 9, 64'h3, 9, 9);       cyc("rst_over_stall", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);           cyc("rst_after", 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 5'(i), 5'(5 - i));
      cyc($sformatf("b2b%0d", i), 1, regs[i], regs[5 - i]);
    end
    drive(0, 0, 0, 0, 0, 0, 7, 7);           cyc("b2b_idle", 0, regs[4], regs[1]);
    for (int i = 0; i < 400; i++) begin
      regs[$urandom_range(0, NR - 1)] = {$urandom, $urandom};
      drive(i == 0 || $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, 1'($urandom), pick(), {$urandom, $urandom}, pick(), pick());
      @(posedge clk);
      #1;
      if (rst) begin
        m_v = 0; m_a = '0; m_b = '0; m_ha = 31; m_hb = 31;
      end else if (!stall) begin
        if (rd_valid_in) begin
          m_a = rv(rd_addr_a); m_b = rv(rd_addr_b); m_ha = rd_addr_a; m_hb = rd_addr_b;
        end
        m_v = rd_valid_in;
      end else if (m_v && wr_en && wr_addr != 5'd31) begin
        if (wr_addr == m_ha) m_a = wr_data;
        if (wr_addr == m_hb) m_b = wr_data;
      end
      chk($sformatf("rnd%0d.valid", i), DW'(rd_valid_out), DW'(m_v));
      chk($sformatf("rnd%0d.a", i), rd_data_a, m_a);
      chk($sformatf("rnd%0d.b", i), rd_data_b, m_b);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_read_port.md
REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of each register and each read-data output.
REQ-002 SHALL have parameter NUM_REGS, default 32: number of architectural registers; ADDR_WIDTH = log2(NUM_REGS) = 5.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port regs_flat, input, NUM_REGS*DATA_WIDTH: current register-array contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port wr_en, input, 1: the write port is committing this cycle.
REQ-007 SHALL have port wr_addr, input, ADDR_WIDTH: write-port register index.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH: write-port data.
REQ-009 SHALL have port rd_valid_in, input, 1: a read request is present.
REQ-010 SHALL have port rd_addr_a, input, ADDR_WIDTH: port A read index.
REQ-011 SHALL have port rd_addr_b, input, ADDR_WIDTH: port B read index.
REQ-012 SHALL have port stall, input, 1: the consumer cannot accept new results; hold outputs.
REQ-013 SHALL have port rd_valid_out, output, 1: rd_data_a/rd_data_b carry an accepted request's result.
REQ-014 SHALL have port rd_data_a, output, DATA_WIDTH: registered port A result.
REQ-015 SHALL have port rd_data_b, output, DATA_WIDTH: registered port B result.

Function
REQ-016 SHALL accept a request on a rising edge when rd_valid_in=1 and stall=0, and SHALL capture both addresses into held-address registers.
REQ-017 SHALL present an accepted request's result on rd_data_a/b with rd_valid_out=1 exactly one cycle after acceptance.
REQ-018 SHALL compute each port's value as follows: 0 if the address is 31 (zero register); otherwise wr_data if wr_en=1 and wr_addr equals the address; otherwise regs_flat[address]. Priority is in that order.
REQ-019 SHALL never bypass wr_data to address 31, even when wr_en=1 and wr_addr=31.
REQ-020 SHALL drive rd_valid_out to 0 on the next edge when stall=0 and rd_valid_in=0; rd_data_a/b SHALL then hold their last values.
REQ-021 SHALL ignore rd_valid_in while stall=1; rd_valid_out and the held addresses SHALL be unchanged.
REQ-022 SHALL, while stall=1 and rd_valid_out=1, refresh a port's held data with wr_data when wr_en=1 and wr_addr equals that port's held address (not 31), so the released result is never stale.
REQ-023 SHALL apply the REQ-022 refresh independently to ports A and B; both SHALL refresh in the same cycle when both held addresses match.
REQ-024 SHALL produce identical results on A and B when rd_addr_a equals rd_addr_b.
REQ-025 SHALL treat indices at or above NUM_REGS (when NUM_REGS < 32) as reading 0.

Reset
REQ-026 SHALL, on a rising edge with rst=1, set rd_valid_out=0, rd_data_a=0, rd_data_b=0, and both held addresses to 31.
REQ-027 SHALL give rst priority over stall, rd_valid_in and wr_en; a request presented in a reset cycle SHALL be dropped.
REQ-028 SHALL produce its first valid result no earlier than two edges after rst deasserts (accept edge, then output).

Structure
REQ-029 SHALL take DATA_WIDTH and NUM_REGS defaults, ADDR_WIDTH and ZERO_REG=31 from a shared package regfile_pkg, which is also used by the write-side regfile logic.
REQ-030 SHALL implement each port as one instance of a sub-module regfile_read_slice, covering address hold, zero and bypass select, output data register and stall refresh. The top level SHALL instantiate it twice and own rd_valid_out.

Verification
REQ-031 Reset: regs_flat[5]=0xAAAA, rst=1 with rd_valid_in=1, addr_a=5 -> rd_valid_out=0, rd_data_a=0 both during reset and one cycle after it.
REQ-032 Plain read: regs[3]=0x1234, regs[7]=0xBEEF, addr_a=3, addr_b=7, valid_in=1 -> next cycle valid_out=1, data_a=0x1234, data_b=0xBEEF.
REQ-033 Bypass: regs[4]=0x11, wr_en=1, wr_addr=4, wr_data=0x99, addr_a=4 in the same cycle -> data_a=0x99; wr_addr=31, wr_data=0x77, addr_b=31 -> data_b=0.
REQ-034 Stall refresh: accept addr_a=9 (regs[9]=0x5), raise stall for 3 cycles with wr_en=1, wr_addr=9, wr_data=0x6 in cycle 2 -> data_a=0x6 and valid_out=1 held through the stall; new requests during the stall are ignored.
REQ-035 Back-to-back: 4 consecutive requests with stall=0, addresses 1,2,3,4 -> valid_out high for 4 consecutive cycles with the matching data, then low with data held at regs[4].
REQ-036 Same address: addr_a=addr_b=12, regs[12]=0xC0DE -> data_a=data_b=0xC0DE.
